// File: rtl/change_pkg.sv
// Shared types and defaults for the change payout stage.
package change_pkg;

  localparam int COIN_W      = 4;
  localparam int DEF_TIMEOUT = 50;
  localparam int DEF_GAP_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } pay_state_t;

endpackage

// File: rtl/sns_sync.sv
// Two-flop synchronizer for the hopper exit sensor with a one-cycle
// pulse on each synchronized rising edge.
module sns_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_q <= 1'b0;
    end else begin
      r_sync1   <= d;
      r_sync2   <= r_sync1;
      r_sync2_q <= r_sync2;
    end
  end

  assign rise = r_sync2 & ~r_sync2_q;

endmodule

// File: rtl/change_payout.sv
// Change payout stage: latches the coin count at vend time and drives the
// hopper one coin at a time, with stall timeout and sticky fault.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a vend strobe
// ST_RUN   | motor on, waiting for the next coin, timeout counting
// ST_GAP   | motor off for GAP_CYC cycles after a confirmed coin
// ST_DONE  | one-cycle completion pulse
// ST_FAULT | hopper stalled or empty; held until reset
module change_payout
  import change_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              can,
  input  logic [COIN_W-1:0] coin,
  input  logic              hop_sns,
  output logic              hop_en,
  output logic [COIN_W-1:0] remain,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  pay_state_t        r_state;
  logic              r_hop_en;
  logic [COIN_W-1:0] r_remain;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              w_rise;
  logic              w_dec_ok;
  logic [COIN_W-1:0] w_remain_dec;
  logic              w_last_coin;

  sns_sync u_sns_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (hop_sns),
    .rise (w_rise)
  );

  // A decrement at zero is suppressed so remain can never wrap.
  assign w_dec_ok     = w_rise && (r_remain != '0);
  assign w_remain_dec = r_remain - COIN_W'(1);
  assign w_last_coin  = w_dec_ok && (w_remain_dec == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hop_en  <= 1'b0;
      r_remain  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (can) begin
            if (coin != '0) begin
              r_remain <= coin;
              r_to_cnt <= '0;
              r_hop_en <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= ST_RUN;
            end else begin
              r_remain <= '0;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end

        ST_RUN: begin
          if (w_last_coin) begin
            r_remain <= '0;
            r_hop_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_dec_ok) begin
            r_remain  <= w_remain_dec;
            r_hop_en  <= 1'b0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (r_to_cnt == TO_LAST) begin
            r_hop_en <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= ST_FAULT;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        // A late sensor edge from the previous coin can still land here.
        ST_GAP: begin
          if (w_last_coin) begin
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            if (w_dec_ok) begin
              r_remain <= w_remain_dec;
            end
            if (r_gap_cnt == GAP_LAST) begin
              r_to_cnt <= '0;
              r_hop_en <= 1'b1;
              r_state  <= ST_RUN;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        ST_FAULT: begin
          r_hop_en <= 1'b0;
          r_busy   <= 1'b0;
          r_err    <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hop_en = r_hop_en;
  assign remain = r_remain;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_change_payout.sv
// Self-checking bench for change_payout: a table of payout scenarios plus
// hand-written reset, fault and sensor-glitch sequences.
module tb_change_payout;

  localparam int TIMEOUT_TB = 50;
  localparam int GAP_TB     = 2;

  logic       clk;
  logic       rst;
  logic       can;
  logic [3:0] coin;
  logic       hop_sns;
  logic       hop_en;
  logic [3:0] remain;
  logic       busy;
  logic       done;
  logic       err;

  change_payout #(.TIMEOUT(TIMEOUT_TB), .GAP_CYC(GAP_TB)) dut (
    .clk     (clk),
    .rst     (rst),
    .can     (can),
    .coin    (coin),
    .hop_sns (hop_sns),
    .hop_en  (hop_en),
    .remain  (remain),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int coin;
    int pulses;
    bit inject;
    int exp_done;
    int exp_err;
    int exp_rem;
    int exp_en;
    int exp_rises;
    int exp_gaps;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  int   q_exp[$];
  int   pulses_left = 0;
  int   exp_remain  = 0;

  int c_done = 0, c_en = 0, c_busy = 0, c_gapcyc = 0, c_gaps = 0, c_rise = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Output monitor: activity counters and the decrement scoreboard.
  initial begin : monitor
    int  prev_rem;
    bit  prev_en;
    bit  prev_rst;
    int  e;
    prev_rem = 0;
    prev_en  = 1'b0;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (done) c_done++;
      if (hop_en) c_en++;
      if (busy) c_busy++;
      if (busy && !hop_en) c_gapcyc++;
      if (prev_en && !hop_en && busy) c_gaps++;
      if (!prev_en && hop_en) c_rise++;
      if (!prev_rst && prev_rem != 0 && int'(remain) == prev_rem - 1) begin
        check("dec_expected", int'(q_exp.size() > 0), 1);
        if (q_exp.size() > 0) begin
          e = q_exp.pop_front();
          check("dec_value", int'(remain), e);
        end
      end
      prev_rem = int'(remain);
      prev_en  = hop_en;
      prev_rst = rst;
    end
  end

  // Hopper model: 5 cycles after each motor start, a 4-cycle sensor pulse.
  initial begin : hopper
    bit last_en;
    last_en = 1'b0;
    forever begin
      @(negedge clk);
      if (hop_en && !last_en && pulses_left > 0) begin
        repeat (5) @(posedge clk);
        #1;
        hop_sns = 1'b1;
        pulses_left--;
        exp_remain--;
        q_exp.push_back(exp_remain);
        repeat (4) @(posedge clk);
        #1 hop_sns = 1'b0;
        last_en = 1'b1;
      end else begin
        last_en = hop_en;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit with_reset);
    int d_done, d_en, d_busy, d_gapcyc, d_gaps, d_rise;
    bit finished;
    if (with_reset) do_reset();
    pulses_left = v.pulses;
    exp_remain  = v.coin;
    d_done = c_done; d_en = c_en; d_busy = c_busy;
    d_gapcyc = c_gapcyc; d_gaps = c_gaps; d_rise = c_rise;

    @(posedge clk);
    #1 can = 1'b1; coin = 4'(v.coin);
    @(posedge clk);
    #1;
    check({tag, "_start_hop_en"}, int'(hop_en), int'(v.coin != 0));
    check({tag, "_start_busy"},   int'(busy),   int'(v.coin != 0));
    check({tag, "_start_done"},   int'(done),   int'(v.coin == 0));
    can = 1'b0; coin = 4'd0;

    if (v.inject) begin
      repeat (2) @(posedge clk);
      #1 can = 1'b1; coin = 4'd9;
      @(posedge clk);
      #1 can = 1'b0; coin = 4'd0;
    end

    finished = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (c_done > d_done || err) begin
        finished = 1'b1;
        break;
      end
    end
    check({tag, "_finished_in_budget"}, int'(finished), 1);
    repeat (5) @(negedge clk);

    check({tag, "_done_pulses"}, c_done - d_done, v.exp_done);
    check({tag, "_err"},         int'(err),       v.exp_err);
    check({tag, "_remain"},      int'(remain),    v.exp_rem);
    check({tag, "_hop_en_cycles"}, c_en - d_en,   v.exp_en);
    check({tag, "_motor_starts"},  c_rise - d_rise, v.exp_rises);
    check({tag, "_gap_windows"},   c_gaps - d_gaps, v.exp_gaps);
    check({tag, "_gap_cycles"},    c_gapcyc - d_gapcyc, v.exp_gaps * GAP_TB);
    check({tag, "_hop_en_end"},  int'(hop_en), 0);
    check({tag, "_busy_end"},    int'(busy),   0);
    check({tag, "_busy_seen"},   int'(c_busy > d_busy), int'(v.coin != 0));
    check({tag, "_scoreboard_empty"}, q_exp.size(), 0);
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t vf;
    vec_t v1;
    int   r0;
    bit   hit;

    rst = 1'b1; can = 1'b0; coin = 4'd0; hop_sns = 1'b0;

    //          coin pul inj done err rem  en  rises gaps
    vecs[0] = '{3,   3,  0,  1,   0,  0,   24,  3,   2};
    vecs[1] = '{0,   0,  0,  1,   0,  0,   0,   0,   0};
    vecs[2] = '{1,   1,  0,  1,   0,  0,   8,   1,   0};
    vecs[3] = '{15,  15, 0,  1,   0,  0,   120, 15,  14};
    vecs[4] = '{2,   1,  0,  0,   1,  1,   58,  2,   1};
    vecs[5] = '{4,   0,  0,  0,   1,  4,   50,  1,   0};
    vecs[6] = '{2,   2,  1,  1,   0,  0,   16,  2,   1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_hop_en", int'(hop_en), 0);
    check("reset_remain", int'(remain), 0);
    check("reset_busy",   int'(busy),   0);
    check("reset_done",   int'(done),   0);
    check("reset_err",    int'(err),    0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Fault is sticky: a later vend is ignored until reset.
    vf = vecs[4];
    run_vec("fault", vf, 1'b1);
    r0 = c_rise;
    @(posedge clk);
    #1 can = 1'b1; coin = 4'd3;
    @(posedge clk);
    #1 can = 1'b0; coin = 4'd0;
    repeat (10) @(negedge clk);
    check("fault_hold_err",    int'(err),    1);
    check("fault_hold_remain", int'(remain), 1);
    check("fault_hold_hop_en", int'(hop_en), 0);
    check("fault_hold_busy",   int'(busy),   0);
    check("fault_hold_starts", c_rise - r0,  0);
    do_reset();
    check("fault_clear_err",    int'(err),    0);
    check("fault_clear_remain", int'(remain), 0);

    // Reset in the middle of a payout, then a normal single-coin vend.
    pulses_left = 2;
    exp_remain  = 5;
    @(posedge clk);
    #1 can = 1'b1; coin = 4'd5;
    @(posedge clk);
    #1 can = 1'b0; coin = 4'd0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (remain == 4'd3) begin
        hit = 1'b1;
        break;
      end
    end
    check("midrst_two_paid", int'(hit), 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_remain", int'(remain), 0);
    check("midrst_hop_en", int'(hop_en), 0);
    check("midrst_busy",   int'(busy),   0);
    check("midrst_done",   int'(done),   0);
    check("midrst_err",    int'(err),    0);
    rst = 1'b0;
    check("midrst_scoreboard_empty", q_exp.size(), 0);
    v1 = vecs[2];
    run_vec("after_rst", v1, 1'b0);

    // Sensor glitches in IDLE are ignored; a pulse alongside the vend is a coin.
    do_reset();
    r0 = c_rise;
    @(posedge clk); #1 hop_sns = 1'b1;
    @(posedge clk); #1 hop_sns = 1'b0;
    @(posedge clk); #1 hop_sns = 1'b1;
    repeat (2) @(posedge clk); #1 hop_sns = 1'b0;
    @(posedge clk); #1 hop_sns = 1'b1;
    @(posedge clk); #1 hop_sns = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_idle_remain", int'(remain), 0);
    check("glitch_idle_busy",   int'(busy),   0);
    check("glitch_idle_starts", c_rise - r0,  0);
    r0 = c_done;
    pulses_left = 1;
    exp_remain  = 1;
    q_exp.push_back(1);
    @(posedge clk);
    #1 can = 1'b1; coin = 4'd2; hop_sns = 1'b1;
    @(posedge clk);
    #1 can = 1'b0; coin = 4'd0; hop_sns = 1'b0;
    check("glitch_load_remain", int'(remain), 2);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_done > r0) begin
        hit = 1'b1;
        break;
      end
    end
    check("glitch_finished", int'(hit), 1);
    repeat (3) @(negedge clk);
    check("glitch_final_remain", int'(remain), 0);
    check("glitch_done_pulses",  c_done - r0,  1);
    check("glitch_err",          int'(err),    0);
    check("glitch_scoreboard_empty", q_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_payout.md
# change_payout

Change-dispensing stage directly downstream of the vending-machine controller. It latches the change-coin count the controller produces at vend time and drives a coin hopper one coin at a time. Each coin is confirmed by the hopper's exit sensor. A stalled or empty hopper is detected by timeout and reported as a sticky fault. The block also reports remaining count, busy and completion status back to the front panel.

## Interface
Parameters:
- `TIMEOUT`, 50: max cycles in RUN without a confirmed coin before fault.
- `GAP_CYC`, 2: motor-off cycles after each confirmed coin before the motor restarts.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `can`  in  1  vend strobe from controller; sampled each edge.
- `coin`  in  4  number of change coins to pay, valid when `can`=1.
- `hop_sns`  in  1  raw hopper exit sensor, asynchronous, high while a coin passes.
- `hop_en`  out  1  hopper motor enable.
- `remain`  out  4  coins still to be paid.
- `busy`  out  1  high in RUN or GAP.
- `done`  out  1  one-cycle pulse when payout completes.
- `err`  out  1  sticky fault flag; cleared only by `rst`.

## Operation
- States: IDLE, RUN, GAP, DONE, FAULT.
- Reset values: state=IDLE, `hop_en`=0, `remain`=0, `busy`=0, `done`=0, `err`=0, timeout counter=0, sync flops=0.
- IDLE, `can`=1, `coin`≠0: latch `remain`←`coin`, clear timeout counter, go to RUN.
- IDLE, `can`=1, `coin`=0: go to DONE; `hop_en` is never asserted.
- RUN: `hop_en`=1 and the timeout counter increments each cycle.
  - On a confirmed sensor edge, `remain` decrements.
  - If the new `remain` is 0, go to DONE.
  - Otherwise clear the counter and go to GAP.
- RUN timeout: when the counter reaches `TIMEOUT`-1 with no edge, go to FAULT.
- GAP: `hop_en`=0 for `GAP_CYC` cycles, then back to RUN with the counter cleared.
  - A confirmed edge in GAP still decrements `remain`.
  - If that makes `remain` 0, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `remain` is 0.
- FAULT: `hop_en`=0, `busy`=0, `err`=1, and `remain` holds the unpaid count.
  - FAULT is left only by `rst`.
  - `can` is ignored in FAULT.
- `can` in RUN, GAP or DONE is ignored. There is no queueing.
- Sensor edges in IDLE, DONE or FAULT are ignored.
- `remain` never wraps: a decrement at 0 is suppressed.

## Timing
- `hop_sns` passes through a 2-flop synchronizer. A confirmed edge means sync2=1 and the previous sync2=0.
  - Latency from raw rise to `remain` decrement: 3 edges.
- `can` sampled at edge k:
  - state=RUN and `hop_en`=1 after edge k.
  - `busy`=1 in the same cycle.
- `coin`=0 case: `done`=1 in the cycle after the `can` edge; IDLE on the following edge.
- Last coin confirmed at edge m: `hop_en`=0 and `done`=1 after m; `done`=0 after m+1.
- Timeout: exactly `TIMEOUT` cycles of `hop_en`=1 without a confirmed edge, then FAULT on the next edge.
- `rst` mid-payout: all outputs return to reset values on that edge; `hop_en` drops immediately.
- `rst` and `can` in the same cycle: `rst` wins.
- All outputs are registered. No combinational path from input to output.

## Structure
- Package `change_pkg`: state enum `pay_state_t`, `COIN_W`=4, default `TIMEOUT` and `GAP_CYC` constants.
- Sub-module `sns_sync`: 2-flop synchronizer plus rising-edge pulse. Ports `clk`, `rst`, `d`, `rise`.
- Top level: FSM, `remain` register, timeout counter sized $clog2(`TIMEOUT`), gap counter.

## Test plan
- `can`=1 with `coin`=3; bench pulses `hop_sns` 4 cycles wide, 5 cycles after each `hop_en` rise.
  - Expect `remain` 3→2→1→0.
  - Expect two `GAP_CYC`=2 motor-off windows.
  - Expect a single `done` pulse; `hop_en`=0 after.
- `can`=1 with `coin`=0 → `done` high for exactly 1 cycle; `hop_en` never 1; `busy` stays 0.
- `coin`=2, one sensor pulse, then silence → after 50 cycles of `hop_en`=1: `err`=1, `remain`=1, `hop_en`=0.
  - A later `can` is ignored until `rst`.
- `coin`=5, two coins paid, then `rst` for 1 cycle → `remain`=0, `hop_en`=0, `busy`=0.
  - A subsequent `can` with `coin`=1 completes normally.
- During a `coin`=2 payout, `can`=1 with `coin`=9 → ignored; `remain` reaches 0 after 2 coins, not 9.
- `hop_sns` glitches while IDLE, plus a 1-cycle pulse on the same edge as `can` → `remain` unaffected by the IDLE glitches.
